// File: rtl/value_fmt_ctrl.sv
// value_fmt_ctrl: formats one WIDTH-bit value as an ASCII character stream
// (binary, hex, unsigned or signed decimal), MSB first, over a valid/ready channel.
module value_fmt_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] req_value_i,
    input  logic [1:0]       req_fmt_i,
    output logic             ch_valid_o,
    input  logic             ch_ready_i,
    output logic [7:0]       ch_data_o,
    output logic             ch_last_o,
    output logic             busy_o
);

    localparam int unsigned NDIG = (WIDTH * 3 + 9) / 10;
    localparam int unsigned BW   = NDIG * 4;
    localparam int unsigned CW   = $clog2(WIDTH + 1);

    localparam logic [1:0] FmtBin  = 2'd0;
    localparam logic [1:0] FmtHex  = 2'd1;
    localparam logic [1:0] FmtSdec = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StConvert,
        StSign,
        StSkip,
        StEmit
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        fmt_q, fmt_d;
    logic [WIDTH-1:0]  val_q, val_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    // CONVERT: shifts left; SKIP/EMIT: characters still to present
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;

    logic [BW-1:0]       bcd_adj;
    logic [BW+WIDTH-1:0] dabble;
    logic [3:0]          top_dig;
    logic [3:0]          top_nib;
    logic                req_neg;

    // Double-dabble step: add 3 to every digit >= 5, then shift {bcd, val} left by one
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        dabble  = {bcd_adj, val_q} << 1;
        top_dig = bcd_q[BW-1 -: 4];
        top_nib = val_q[WIDTH-1 -: 4];
        req_neg = (req_fmt_i == FmtSdec) && req_value_i[WIDTH-1];
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        fmt_d      = fmt_q;
        val_d      = val_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        ch_valid_o = 1'b0;
        ch_data_o  = 8'h00;
        ch_last_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    fmt_d = req_fmt_i;
                    neg_d = req_neg;
                    // 0 - value in WIDTH bits; the most negative value maps onto itself,
                    // which is exactly its unsigned magnitude
                    val_d = req_neg ? ({WIDTH{1'b0}} - req_value_i) : req_value_i;
                    bcd_d = '0;
                    if (req_fmt_i == FmtBin) begin
                        cnt_d   = CW'(WIDTH);
                        state_d = StEmit;
                    end else if (req_fmt_i == FmtHex) begin
                        cnt_d   = CW'(WIDTH / 4);
                        state_d = StEmit;
                    end else begin
                        cnt_d   = CW'(WIDTH);
                        state_d = StConvert;
                    end
                end
            end
            StConvert: begin
                bcd_d = dabble[BW+WIDTH-1:WIDTH];
                val_d = dabble[WIDTH-1:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    cnt_d   = CW'(NDIG);
                    state_d = neg_q ? StSign : StSkip;
                end
            end
            StSign: begin
                ch_valid_o = 1'b1;
                ch_data_o  = 8'h2D;
                if (ch_ready_i) begin
                    state_d = StSkip;
                end
            end
            StSkip: begin
                if (top_dig == 4'd0 && cnt_q > CW'(1)) begin
                    bcd_d = bcd_q << 4;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // First significant digit is presented here directly to save a cycle
                    ch_valid_o = 1'b1;
                    ch_data_o  = 8'h30 + {4'h0, top_dig};
                    ch_last_o  = (cnt_q == CW'(1));
                    if (ch_ready_i) begin
                        bcd_d   = bcd_q << 4;
                        cnt_d   = cnt_q - CW'(1);
                        state_d = (cnt_q == CW'(1)) ? StIdle : StEmit;
                    end
                end
            end
            StEmit: begin
                ch_valid_o = 1'b1;
                ch_last_o  = (cnt_q == CW'(1));
                if (fmt_q == FmtBin) begin
                    ch_data_o = 8'h30 + {7'h00, val_q[WIDTH-1]};
                end else if (fmt_q == FmtHex) begin
                    ch_data_o = (top_nib < 4'd10) ? (8'h30 + {4'h0, top_nib})
                                                  : (8'h37 + {4'h0, top_nib});
                end else begin
                    ch_data_o = 8'h30 + {4'h0, top_dig};
                end
                if (ch_ready_i) begin
                    cnt_d = cnt_q - CW'(1);
                    if (fmt_q == FmtBin) begin
                        val_d = val_q << 1;
                    end else if (fmt_q == FmtHex) begin
                        val_d = val_q << 4;
                    end else begin
                        bcd_d = bcd_q << 4;
                    end
                    if (cnt_q == CW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign req_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);

    // State registers with synchronous reset; reset abandons any stream in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            fmt_q   <= 2'd0;
            val_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fmt_q   <= fmt_d;
            val_q   <= val_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: tb/tb_value_fmt_ctrl.sv
// Directed testbench for value_fmt_ctrl (WIDTH=16).
module tb_value_fmt_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [15:0] req_value_i;
    logic [1:0]  req_fmt_i;
    logic        ch_valid_o;
    logic        ch_ready_i;
    logic [7:0]  ch_data_o;
    logic        ch_last_o;
    logic        busy_o;

    int tests;
    int fails;

    value_fmt_ctrl #(.WIDTH(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_value_i (req_value_i),
        .req_fmt_i   (req_fmt_i),
        .ch_valid_o  (ch_valid_o),
        .ch_ready_i  (ch_ready_i),
        .ch_data_o   (ch_data_o),
        .ch_last_o   (ch_last_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Present a request at the current negedge; return at the next negedge (cycle T+1)
    task automatic send(input logic [15:0] v, input logic [1:0] f, input bit hold,
                        output bit acc);
        req_valid_i = 1'b1;
        req_value_i = v;
        req_fmt_i   = f;
        acc         = req_ready_o;
        @(negedge clk_i);
        if (!hold) req_valid_i = 1'b0;
    endtask

    // Gather one stream, optionally stalling stall_n cycles on character stall_idx
    task automatic collect(input int stall_idx, input int stall_n, output logic [255:0] s,
                           output int n, output int first, output int unstable,
                           output int early, output bit tmo);
        int         stalls;
        logic [7:0] held;
        bit         done;
        s = '0; n = 0; first = -1; unstable = 0; early = 0; tmo = 1'b1;
        stalls = 0; held = 8'h00; done = 1'b0;
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            if (req_valid_i && req_ready_o) early++;
            ch_ready_i = 1'b1;
            if (ch_valid_o) begin
                if (first < 0) first = cyc;
                if (n == stall_idx && stalls > 0 && ch_data_o !== held) unstable++;
                if (n == stall_idx && stalls < stall_n) begin
                    held       = ch_data_o;
                    ch_ready_i = 1'b0;
                    stalls++;
                end else begin
                    s = {s[247:0], ch_data_o};
                    n++;
                    if (ch_last_o) begin
                        done = 1'b1;
                        tmo  = 1'b0;
                    end
                end
            end else if (n == stall_idx && stalls > 0) begin
                unstable++;
            end
            @(negedge clk_i);
        end
        ch_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        tests++;
        if (ch_valid_o !== 1'b0 || ch_last_o !== 1'b0 || ch_data_o !== 8'h00 ||
            busy_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b last=%b data=%h busy=%b, want 0 0 00 0",
                     ch_valid_o, ch_last_o, ch_data_o, busy_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
    endtask

    task automatic test_hex();
        logic [255:0] s; int n, first, unst, early; bit tmo, acc;
        send(16'h00AF, 2'd1, 1'b0, acc);
        tests++;
        if (acc !== 1'b1 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL hex_accept: acc=%b busy=%b want 1 1", acc, busy_o);
        end
        collect(-1, 0, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || s !== 256'("00AF") || n != 4) begin
            fails++;
            $display("FAIL hex_stream: got '%s' n=%0d tmo=%b want '00AF' n=4", s, n, tmo);
        end
        tests++;
        if (first != 1) begin
            fails++;
            $display("FAIL hex_latency: first valid at T+%0d want T+1", first);
        end
        tests++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL hex_ready_after: ready=%b busy=%b want 1 0", req_ready_o, busy_o);
        end
    endtask

    task automatic test_bin();
        logic [255:0] s; int n, first, unst, early; bit tmo, acc;
        send(16'h8001, 2'd0, 1'b0, acc);
        collect(-1, 0, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || n != 16 || s !== 256'("1000000000000001")) begin
            fails++;
            $display("FAIL bin_stream: got '%s' n=%0d tmo=%b want '1000000000000001' n=16",
                     s, n, tmo);
        end
        tests++;
        if (first != 1) begin
            fails++;
            $display("FAIL bin_latency: first at T+%0d want T+1", first);
        end
    endtask

    task automatic test_udec();
        logic [255:0] s; int n, first, unst, early; bit tmo, acc;
        send(16'h0000, 2'd2, 1'b0, acc);
        collect(-1, 0, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || n != 1 || s !== 256'("0")) begin
            fails++;
            $display("FAIL udec_zero: got '%s' n=%0d tmo=%b want '0' n=1", s, n, tmo);
        end
        tests++;
        if (first != 21) begin
            fails++;
            $display("FAIL udec_zero_latency: first at T+%0d want T+21", first);
        end
        send(16'hFFFF, 2'd2, 1'b0, acc);
        collect(-1, 0, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || n != 5 || s !== 256'("65535")) begin
            fails++;
            $display("FAIL udec_max: got '%s' n=%0d tmo=%b want '65535'", s, n, tmo);
        end
        tests++;
        if (first != 17) begin
            fails++;
            $display("FAIL udec_max_latency: first at T+%0d want T+17", first);
        end
    endtask

    task automatic test_sdec();
        logic [255:0] s; int n, first, unst, early; bit tmo, acc;
        send(16'hFFF6, 2'd3, 1'b0, acc);
        collect(-1, 0, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || n != 3 || s !== 256'("-10")) begin
            fails++;
            $display("FAIL sdec_m10: got '%s' n=%0d tmo=%b want '-10'", s, n, tmo);
        end
        send(16'h8000, 2'd3, 1'b0, acc);
        collect(-1, 0, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || n != 6 || s !== 256'("-32768")) begin
            fails++;
            $display("FAIL sdec_min: got '%s' n=%0d tmo=%b want '-32768'", s, n, tmo);
        end
        send(16'h7FFF, 2'd3, 1'b0, acc);
        collect(-1, 0, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || n != 5 || s !== 256'("32767")) begin
            fails++;
            $display("FAIL sdec_max: got '%s' n=%0d tmo=%b want '32767'", s, n, tmo);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] s; int n, first, unst, early; bit tmo, acc;
        send(16'h1234, 2'd1, 1'b1, acc);
        req_value_i = 16'hBEEF;
        collect(1, 3, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || n != 4 || s !== 256'("1234")) begin
            fails++;
            $display("FAIL bp_stream: got '%s' n=%0d tmo=%b want '1234'", s, n, tmo);
        end
        tests++;
        if (unst != 0) begin
            fails++;
            $display("FAIL bp_hold: %0d unstable cycles while stalled, want 0", unst);
        end
        tests++;
        if (early != 0) begin
            fails++;
            $display("FAIL bp_no_accept: %0d accepts during stream, want 0", early);
        end
        tests++;
        if (req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL bp_ready_after: got %b want 1", req_ready_o);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        collect(-1, 0, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || n != 4 || s !== 256'("BEEF") || first != 1) begin
            fails++;
            $display("FAIL bp_second: got '%s' n=%0d first=%0d want 'BEEF' n=4 first=1",
                     s, n, first);
        end
    endtask

    task automatic test_reset_abort();
        logic [255:0] s; int n, first, unst, early; bit tmo, acc;
        send(16'hFFFF, 2'd0, 1'b0, acc);
        ch_ready_i = 1'b1;
        repeat (4) @(negedge clk_i);
        tests++;
        if (ch_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL abort_midstream: valid=%b want 1 before reset", ch_valid_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        tests++;
        if (ch_valid_o !== 1'b0 || busy_o !== 1'b0 || ch_last_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_outputs: valid=%b busy=%b last=%b want 0 0 0",
                     ch_valid_o, busy_o, ch_last_o);
        end
        @(negedge clk_i);
        send(16'h00AF, 2'd1, 1'b0, acc);
        collect(-1, 0, s, n, first, unst, early, tmo);
        tests++;
        if (tmo || n != 4 || s !== 256'("00AF") || acc !== 1'b1) begin
            fails++;
            $display("FAIL abort_resume: got '%s' n=%0d acc=%b want '00AF' n=4", s, n, acc);
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_value_i = 16'h0000;
        req_fmt_i   = 2'd0;
        ch_ready_i  = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_hex();
        test_bin();
        test_udec();
        test_sdec();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
